// File: rtl/gobou_fc_pkg.sv
// gobou_fc shared definitions: layer geometry, FSM states
// and the per-lane shift/saturate/ReLU output function.
package gobou_fc_pkg;

    localparam int DWIDTH  = 16;
    localparam int FRAC    = 8;
    localparam int CORE    = 8;
    localparam int IMGSIZE = 12;
    localparam int NETSIZE = 14;
    localparam int LWIDTH  = 10;

    // accumulator holds total_in full-width products plus the bias
    localparam int ACCW = 2 * DWIDTH + LWIDTH;
    // lane select width and output-index width (tile*CORE + k)
    localparam int LSEL = $clog2(CORE);
    localparam int OW   = LWIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    // floor shift by FRAC, clamp to the signed DWIDTH range,
    // then optionally clamp negatives to zero
    function automatic logic [DWIDTH-1:0] sat_shift(
        input logic signed [ACCW-1:0] acc,
        input logic                   relu
    );
        logic signed [ACCW-1:0] s;
        logic signed [ACCW-1:0] hi;
        logic signed [ACCW-1:0] lo;
        hi = '0;
        hi[DWIDTH-2:0] = '1;
        lo = '1;
        lo[DWIDTH-2:0] = '0;
        s = acc >>> FRAC;
        if (relu && (s < 0)) begin
            sat_shift = '0;
        end else if (s > hi) begin
            sat_shift = hi[DWIDTH-1:0];
        end else if (s < lo) begin
            sat_shift = lo[DWIDTH-1:0];
        end else begin
            sat_shift = s[DWIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/fc_lane.sv
// fc_lane: one output channel of a tile -- registered multiply,
// wide accumulator with bias preload, saturating output.
module fc_lane
    import gobou_fc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bias_ld_i,
    input  logic              mul_en_i,
    input  logic              acc_en_i,
    input  logic              relu_i,
    input  logic [DWIDTH-1:0] x_i,
    input  logic [DWIDTH-1:0] w_i,
    output logic [DWIDTH-1:0] res_o
);

    logic signed [2*DWIDTH-1:0] prod_q;
    logic signed [ACCW-1:0]     acc_q;
    logic signed [2*DWIDTH-1:0] prod_d;
    logic signed [ACCW-1:0]     bias_d;

    // sign-extend operands before multiplying; bias enters pre-scaled
    always_comb begin
        prod_d = (2*DWIDTH)'($signed(x_i)) * (2*DWIDTH)'($signed(w_i));
        bias_d = ACCW'($signed(w_i)) <<< FRAC;
    end

    // product register and accumulator (bias load overrides add)
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (mul_en_i) begin
                prod_q <= prod_d;
            end
            if (bias_ld_i) begin
                acc_q <= bias_d;
            end else if (acc_en_i) begin
                acc_q <= acc_q + ACCW'(prod_q);
            end
        end
    end

    assign res_o = sat_shift(acc_q, relu_i);

endmodule

// File: rtl/gobou_fc.sv
// gobou_fc: tiled fully-connected layer engine. Sequences weight
// and image reads per tile, then serialises lane results to memory.
module gobou_fc
    import gobou_fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     relu_en,
    input  logic [LWIDTH-1:0]        total_in,
    input  logic [LWIDTH-1:0]        total_out,
    input  logic [IMGSIZE-1:0]       in_base,
    input  logic [IMGSIZE-1:0]       out_base,
    input  logic [DWIDTH-1:0]        read_img,
    input  logic [CORE*DWIDTH-1:0]   read_net,
    output logic                     ack,
    output logic                     busy,
    output logic                     img_we,
    output logic [IMGSIZE-1:0]       img_addr,
    output logic [DWIDTH-1:0]        write_img,
    output logic [NETSIZE-1:0]       net_addr
);

    state_e             state_q, state_d;
    logic [LWIDTH-1:0]  idx_q, idx_d;
    logic [NETSIZE-1:0] tbase_q, tbase_d;
    logic [OW-1:0]      obase_q, obase_d;
    logic               cfg_ld;

    logic               relu_q;
    logic [LWIDTH-1:0]  tin_q;
    logic [LWIDTH-1:0]  tout_q;
    logic [IMGSIZE-1:0] inb_q;
    logic [IMGSIZE-1:0] outb_q;

    logic               bias_ld_q;
    logic               mul_en_q;
    logic               acc_en_q;

    logic [DWIDTH-1:0]  res [CORE];

    logic [OW-1:0]      pos_nx;
    logic               lane_last;
    logic               tile_more;

    // lane bookkeeping for the output serialiser
    always_comb begin
        pos_nx    = obase_q + OW'(idx_q) + OW'(1);
        lane_last = (idx_q[LSEL-1:0] == LSEL'(CORE - 1)) ||
                    (pos_nx >= {1'b0, tout_q});
        tile_more = (obase_q + OW'(CORE)) < {1'b0, tout_q};
    end

    // next-state, address generation and output drive
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tbase_d   = tbase_q;
        obase_d   = obase_q;
        cfg_ld    = 1'b0;
        ack       = 1'b0;
        busy      = (state_q != S_IDLE);
        img_we    = 1'b0;
        img_addr  = '0;
        write_img = '0;
        net_addr  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cfg_ld  = 1'b1;
                    idx_d   = '0;
                    tbase_d = '0;
                    obase_d = '0;
                    state_d = (total_out == '0) ? S_DONE : S_BIAS;
                end
            end
            S_BIAS: begin
                net_addr = tbase_q;
                idx_d    = '0;
                state_d  = (tin_q == '0) ? S_DRAIN : S_ACCUM;
            end
            S_ACCUM: begin
                net_addr = tbase_q + NETSIZE'(idx_q) + NETSIZE'(1);
                img_addr = inb_q + IMGSIZE'(idx_q);
                if (idx_q == tin_q - LWIDTH'(1)) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + LWIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (idx_q == LWIDTH'(1)) begin
                    idx_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    idx_d = idx_q + LWIDTH'(1);
                end
            end
            S_WRITE: begin
                img_we    = 1'b1;
                img_addr  = outb_q + IMGSIZE'(obase_q) + IMGSIZE'(idx_q);
                write_img = res[idx_q[LSEL-1:0]];
                if (lane_last) begin
                    idx_d = '0;
                    if (tile_more) begin
                        obase_d = obase_q + OW'(CORE);
                        tbase_d = tbase_q + NETSIZE'(tin_q) + NETSIZE'(1);
                        state_d = S_BIAS;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    idx_d = idx_q + LWIDTH'(1);
                end
            end
            S_DONE: begin
                ack     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state, counters, latched configuration and pipeline strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tbase_q   <= '0;
            obase_q   <= '0;
            relu_q    <= 1'b0;
            tin_q     <= '0;
            tout_q    <= '0;
            inb_q     <= '0;
            outb_q    <= '0;
            bias_ld_q <= 1'b0;
            mul_en_q  <= 1'b0;
            acc_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tbase_q   <= tbase_d;
            obase_q   <= obase_d;
            bias_ld_q <= (state_q == S_BIAS);
            mul_en_q  <= (state_q == S_ACCUM);
            acc_en_q  <= mul_en_q;
            if (cfg_ld) begin
                relu_q <= relu_en;
                tin_q  <= total_in;
                tout_q <= total_out;
                inb_q  <= in_base;
                outb_q <= out_base;
            end
        end
    end

    for (genvar k = 0; k < CORE; k++) begin : g_lane
        fc_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .bias_ld_i (bias_ld_q),
            .mul_en_i  (mul_en_q),
            .acc_en_i  (acc_en_q),
            .relu_i    (relu_q),
            .x_i       (read_img),
            .w_i       (read_net[k*DWIDTH +: DWIDTH]),
            .res_o     (res[k])
        );
    end

endmodule

// File: tb/tb_gobou_fc.sv
// Scoreboard bench for gobou_fc: directed layers with
// hand-computed results, memories modelled with 1-cycle reads.
module tb_gobou_fc;
    import gobou_fc_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req;
    logic                   relu_en;
    logic [LWIDTH-1:0]      total_in;
    logic [LWIDTH-1:0]      total_out;
    logic [IMGSIZE-1:0]     in_base;
    logic [IMGSIZE-1:0]     out_base;
    logic [DWIDTH-1:0]      read_img;
    logic [CORE*DWIDTH-1:0] read_net;
    logic                   ack;
    logic                   busy;
    logic                   img_we;
    logic [IMGSIZE-1:0]     img_addr;
    logic [DWIDTH-1:0]      write_img;
    logic [NETSIZE-1:0]     net_addr;

    gobou_fc dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .relu_en   (relu_en),
        .total_in  (total_in),
        .total_out (total_out),
        .in_base   (in_base),
        .out_base  (out_base),
        .read_img  (read_img),
        .read_net  (read_net),
        .ack       (ack),
        .busy      (busy),
        .img_we    (img_we),
        .img_addr  (img_addr),
        .write_img (write_img),
        .net_addr  (net_addr)
    );

    always #5 clk = ~clk;

    logic [DWIDTH-1:0]      img_mem [0:(1<<IMGSIZE)-1];
    logic [CORE*DWIDTH-1:0] net_mem [0:(1<<NETSIZE)-1];

    always @(posedge clk) begin
        read_img <= img_mem[img_addr];
        read_net <= net_mem[net_addr];
        if (img_we) img_mem[img_addr] <= write_img;
    end

    typedef struct {
        logic [IMGSIZE-1:0] a;
        logic [DWIDTH-1:0]  d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  vecs = 0;
    int  errs = 0;
    int  wr_cnt = 0;

    // monitor: every write the DUT issues is matched against the queue
    always @(negedge clk) begin
        if (!rst && img_we) begin
            wr_cnt++;
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write addr=%h data=%h",
                         img_addr, write_img);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.a !== img_addr || mon_e.d !== write_img) begin
                    errs++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             img_addr, write_img, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic expect_wr(input int a, input int d);
        wr_t e;
        e.a = IMGSIZE'(a);
        e.d = DWIDTH'(d);
        exp_q.push_back(e);
    endtask

    task automatic set_w(input int a, input int k, input int v);
        net_mem[a][k*DWIDTH +: DWIDTH] = DWIDTH'(v);
    endtask

    task automatic set_all(input int a, input int v);
        for (int k = 0; k < CORE; k++) set_w(a, k, v);
    endtask

    // layer of test 1: x=[1,2,3,4], w lane k = k+1, lane1 optionally negated
    task automatic fill_t1(input bit neg1);
        for (int i = 0; i < 4; i++) img_mem[12'h100 + i] = DWIDTH'((i + 1) << 8);
        set_all(0, 0);
        for (int i = 1; i <= 4; i++) begin
            for (int k = 0; k < CORE; k++) set_w(i, k, (k + 1) << 8);
            if (neg1) set_w(i, 1, -(2 << 8));
        end
    endtask

    task automatic run_layer(input bit relu, input int tin, input int tout,
                             input int inb, input int outb,
                             input int exp_cyc, input bit poke);
        int n;
        @(negedge clk);
        relu_en   = relu;
        total_in  = LWIDTH'(tin);
        total_out = LWIDTH'(tout);
        in_base   = IMGSIZE'(inb);
        out_base  = IMGSIZE'(outb);
        wr_cnt    = 0;
        req       = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 1;
        chk("busy_after_req", {31'b0, busy}, 32'd1);
        while (!ack && n < 400) begin
            if (poke && n == 4) begin
                req       = 1'b1;
                relu_en   = ~relu_en;
                total_in  = 10'd7;
                total_out = 10'd1;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        chk("ack_cycle", n, exp_cyc);
        chk("busy_at_ack", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("ack_drop", {31'b0, ack}, 32'd0);
        chk("busy_drop", {31'b0, busy}, 32'd0);
        chk("write_count", wr_cnt, tout);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        req = 1'b0;
        relu_en = 1'b0;
        total_in = '0;
        total_out = '0;
        in_base = '0;
        out_base = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_we", {31'b0, img_we}, 0);
        chk("rst_img_addr", {20'b0, img_addr}, 0);
        chk("rst_net_addr", {18'b0, net_addr}, 0);
        chk("rst_wdata", {16'b0, write_img}, 0);
        @(negedge clk);
        rst = 1'b0;

        // test 1: basic tile
        fill_t1(1'b0);
        expect_wr(12'h200, 16'h0A00);
        expect_wr(12'h201, 16'h1400);
        expect_wr(12'h202, 16'h1E00);
        run_layer(1'b0, 4, 3, 12'h100, 12'h200, 11, 1'b0);

        // test 2: negative lane with and without ReLU
        fill_t1(1'b1);
        expect_wr(12'h210, 16'h0A00);
        expect_wr(12'h211, 16'h0000);
        expect_wr(12'h212, 16'h1E00);
        run_layer(1'b1, 4, 3, 12'h100, 12'h210, 11, 1'b0);
        expect_wr(12'h220, 16'h0A00);
        expect_wr(12'h221, 16'hEC00);
        expect_wr(12'h222, 16'h1E00);
        run_layer(1'b0, 4, 3, 12'h100, 12'h220, 11, 1'b0);

        // test 3: saturation both directions
        for (int i = 0; i < 4; i++) img_mem[12'h300 + i] = 16'h7FFF;
        set_all(0, 0);
        for (int i = 1; i <= 4; i++) set_all(i, 16'h7FFF);
        expect_wr(12'h320, 16'h7FFF);
        expect_wr(12'h321, 16'h7FFF);
        run_layer(1'b0, 4, 2, 12'h300, 12'h320, 10, 1'b0);
        for (int i = 1; i <= 4; i++) set_all(i, 16'h8001);
        expect_wr(12'h330, 16'h8000);
        expect_wr(12'h331, 16'h8000);
        run_layer(1'b0, 4, 2, 12'h300, 12'h330, 10, 1'b0);

        // test 4: two tiles, output addresses wrap past the top
        img_mem[12'h400] = 16'h0200;
        for (int k = 0; k < CORE; k++) begin
            set_w(0, k, k);
            set_w(2, k, CORE + k);
        end
        set_all(1, 16'h0100);
        set_all(3, 16'h0100);
        for (int j = 0; j < 10; j++) expect_wr((12'hFFC + j) & 12'hFFF, j + 512);
        run_layer(1'b0, 1, 10, 12'h400, 12'hFFC, 19, 1'b0);

        // test 5: bias-only layer, then empty layer
        set_w(0, 0, 5);
        set_w(0, 1, -3);
        expect_wr(12'h500, 16'h0005);
        expect_wr(12'h501, 16'hFFFD);
        run_layer(1'b0, 0, 2, 12'h400, 12'h500, 6, 1'b0);
        run_layer(1'b0, 4, 0, 12'h400, 12'h510, 1, 1'b0);

        // test 6: reset aborts a layer mid-accumulation
        fill_t1(1'b0);
        @(negedge clk);
        relu_en = 1'b0;
        total_in = 10'd4;
        total_out = 10'd3;
        in_base = 12'h100;
        out_base = 12'h600;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_we", {31'b0, img_we}, 0);
        chk("abort_img_addr", {20'b0, img_addr}, 0);
        chk("abort_net_addr", {18'b0, net_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack) seen++;
        end
        chk("abort_no_ack", seen, 0);

        // full layer after abort, with a req pulse while busy
        expect_wr(12'h700, 16'h0A00);
        expect_wr(12'h701, 16'h1400);
        expect_wr(12'h702, 16'h1E00);
        run_layer(1'b0, 4, 3, 12'h100, 12'h700, 11, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle_after_poke", {31'b0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
